// File: rtl/gf_div_seq.sv
// Sequential GF(2^m) divider: q = a * b^(2^m-2) mod p, with one shared
// shift-and-xor multiplier stepped through SQ/MUL/FIN by a small FSM.
module gf_div_seq #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   m,
    input  logic [W:0]   p,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ,
        S_MUL,
        S_FIN,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [2:0]   m_q, m_d;
    logic [2:0]   i_q, i_d;
    logic [W:0]   p_q, p_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] sq_q, sq_d;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] q_q, q_d;
    logic         err_q, err_d;

    logic [W-1:0] mul_x, mul_y, mul_r;
    logic [W-1:0] in_mask;
    logic         illegal;

    // Bit idx of v, reading 0 when idx lies beyond the vector.
    function automatic logic bit_at(input logic [W:0] v, input logic [2:0] idx);
        logic r;
        r = 1'b0;
        for (int k = 0; k <= W; k++) begin
            if (k == int'(idx)) r = v[k];
        end
        return r;
    endfunction

    // Carry-less multiply with reduction folded into each shift step.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [2:0] deg, input logic [W:0] poly);
        logic [W:0]   pm;
        logic [W:0]   sh;
        logic [W-1:0] r;
        pm = '0;
        for (int k = 0; k <= W; k++) begin
            if (k <= int'(deg)) pm[k] = poly[k];
        end
        sh = {1'b0, x};
        r  = '0;
        for (int k = 0; k < W; k++) begin
            if (y[k]) r = r ^ sh[W-1:0];
            sh = sh << 1;
            if (bit_at(sh, deg)) sh = sh ^ pm;
        end
        return r;
    endfunction

    always_comb begin
        in_mask = '0;
        for (int k = 0; k < W; k++) begin
            in_mask[k] = (k < int'(m));
        end
        illegal = (m < 3'd2) || (int'(m) > W) || !bit_at(p, m) || ((b & in_mask) == '0);
    end

    // Operand routing for the single shared multiplier.
    always_comb begin
        mul_x = acc_q;
        mul_y = sq_q;
        case (state_q)
            S_SQ:    mul_x = sq_q;
            S_FIN:   mul_y = a_q;
            default: ;
        endcase
        mul_r = gf_mul(mul_x, mul_y, m_q, p_q);
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        i_d     = i_q;
        p_d     = p_q;
        a_d     = a_q;
        sq_d    = sq_q;
        acc_d   = acc_q;
        q_d     = q_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = m;
                    p_d     = p;
                    a_d     = a & in_mask;
                    sq_d    = b & in_mask;
                    acc_d   = W'(1);
                    i_d     = 3'd1;
                    q_d     = '0;
                    err_d   = illegal;
                    state_d = illegal ? S_DONE : S_SQ;
                end
            end
            S_SQ: begin
                sq_d    = mul_r;
                state_d = S_MUL;
            end
            S_MUL: begin
                acc_d   = mul_r;
                i_d     = i_q + 3'd1;
                state_d = (i_q == m_q - 3'd1) ? S_FIN : S_SQ;
            end
            S_FIN: begin
                q_d     = mul_r;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: reset is synchronous and clears every register, so an aborted
    // operation leaves nothing behind that could later surface as a result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            i_q     <= '0;
            p_q     <= '0;
            a_q     <= '0;
            sq_q    <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            i_q     <= i_d;
            p_q     <= p_d;
            a_q     <= a_d;
            sq_q    <= sq_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q == S_SQ) || (state_q == S_MUL) || (state_q == S_FIN);
    assign done = (state_q == S_DONE);
    assign err  = err_q;
    assign q    = q_q;

endmodule

// File: tb/tb_gf_div_seq.sv
// Self-checking bench for gf_div_seq: directed cases, exhaustive fields and
// random requests compared against an integer polynomial reference model.
module tb_gf_div_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] m;
    logic [4:0] p;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] q;

    int n_checks = 0;
    int n_errors = 0;

    gf_div_seq #(.W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .m     (m),
        .p     (p),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .q     (q)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full carry-less product, then polynomial long division by p.
    function automatic int ref_mul(input int x, input int y, input int mm, input int pp);
        int prod;
        int pm;
        prod = 0;
        pm   = pp & ((1 << (mm + 1)) - 1);
        for (int k = 0; k < 8; k++) begin
            if (((y >> k) & 1) == 1) prod = prod ^ (x << k);
        end
        for (int d = 2 * mm - 2; d >= mm; d--) begin
            if (((prod >> d) & 1) == 1) prod = prod ^ (pm << (d - mm));
        end
        return prod;
    endfunction

    function automatic bit ref_legal(input int mm, input int pp, input int bb);
        if (mm < 2 || mm > 4) return 1'b0;
        if (((pp >> mm) & 1) == 0) return 1'b0;
        if ((bb & ((1 << mm) - 1)) == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int ref_div(input int mm, input int pp, input int aa, input int bb);
        int mask;
        int r;
        if (!ref_legal(mm, pp, bb)) return 0;
        mask = (1 << mm) - 1;
        r    = 1;
        for (int e = 0; e < (1 << mm) - 2; e++) r = ref_mul(r, bb & mask, mm, pp);
        return ref_mul(aa & mask, r, mm, pp);
    endfunction

    // Issues one request in the cycle after the previous negedge and returns at
    // the negedge of the done cycle (or when the cycle budget runs out).
    task automatic run_op(input logic [2:0] mm, input logic [4:0] pp, input logic [3:0] aa,
                          input logic [3:0] bb, output logic [3:0] q_got);
        bit legal;
        int q_exp;
        int lat_exp;
        int cyc;
        bit busy_ok;
        legal   = ref_legal(int'(mm), int'(pp), int'(bb));
        q_exp   = ref_div(int'(mm), int'(pp), int'(aa), int'(bb));
        lat_exp = legal ? 2 * int'(mm) : 1;
        @(negedge clk);
        m = mm; p = pp; a = aa; b = bb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m = 3'($urandom); p = 5'($urandom); a = 4'($urandom); b = 4'($urandom);
        check("q_cleared_at_accept", 32'(q), 32'd0);
        cyc     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(lat_exp));
        check("busy_while_running", 32'(busy_ok), 32'd1);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("err", 32'(err), 32'(!legal));
        check("q", 32'(q), 32'(q_exp));
        q_got = q;
    endtask

    logic [3:0] qg;
    int         n_done;

    initial begin
        rst_n = 1'b0; start = 1'b0; m = '0; p = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        rst_n = 1'b1;

        // Directed cases with hand-derived results.
        run_op(3'd3, 5'b01011, 4'd6, 4'd7, qg);
        check("dir_6_div_7", 32'(qg), 32'd5);
        check("dir_6_div_7_mul_back", 32'(ref_mul(int'(qg), 7, 3, 11)), 32'd6);
        run_op(3'd3, 5'b01011, 4'd1, 4'd2, qg);
        check("dir_inv_x_m3", 32'(qg), 32'd5);
        run_op(3'd4, 5'b11001, 4'd1, 4'd2, qg);
        check("dir_inv_x_m4", 32'(qg), 32'hC);
        run_op(3'd4, 5'b11001, 4'd0, 4'd9, qg);
        check("dir_zero_dividend", 32'(qg), 32'd0);
        run_op(3'd4, 5'b11001, 4'hB, 4'd0, qg);
        check("dir_div_by_zero_err", 32'(err), 32'd1);
        run_op(3'd5, 5'b11001, 4'd3, 4'd3, qg);
        check("dir_m5_err", 32'(err), 32'd1);
        run_op(3'd3, 5'b00011, 4'd3, 4'd3, qg);
        check("dir_bad_poly_err", 32'(err), 32'd1);

        // A start in the done cycle must be ignored.
        start = 1'b1; m = 3'd3; p = 5'b01011; a = 4'd1; b = 4'd1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_busy", 32'(busy), 32'd0);
        check("start_in_done_no_done", 32'(done), 32'd0);

        // Start while busy: ignored, exactly one done with the original result.
        @(negedge clk);
        m = 3'd4; p = 5'b11001; a = 4'd7; b = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        m = 3'd3; p = 5'b01011; a = 4'd2; b = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        qg     = '0;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) begin
                n_done++;
                qg = q;
            end
            @(negedge clk);
        end
        check("busy_start_single_done", 32'(n_done), 32'd1);
        check("busy_start_orig_result", 32'(qg), 32'(ref_div(4, 25, 7, 3)));

        // Reset while in MUL: outputs clear and the operation never completes.
        @(negedge clk);
        m = 3'd4; p = 5'b11001; a = 4'd5; b = 4'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midop_rst_busy", 32'(busy), 32'd0);
        check("midop_rst_done", 32'(done), 32'd0);
        check("midop_rst_q", 32'(q), 32'd0);
        check("midop_rst_err", 32'(err), 32'd0);
        rst_n  = 1'b1;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            if (done === 1'b1) n_done++;
            @(negedge clk);
        end
        check("midop_rst_no_done", 32'(n_done), 32'd0);
        run_op(3'd4, 5'b11001, 4'd5, 4'd6, qg);

        // Exhaustive over two irreducible fields, back-to-back requests.
        for (int aa = 0; aa < 8; aa++) begin
            for (int bb = 1; bb < 8; bb++) begin
                run_op(3'd3, 5'b01011, 4'(aa), 4'(bb), qg);
                check("exh3_mul_back", 32'(ref_mul(int'(qg), bb, 3, 11)), 32'(aa));
            end
        end
        for (int aa = 0; aa < 16; aa++) begin
            for (int bb = 1; bb < 16; bb++) begin
                run_op(3'd4, 5'b11001, 4'(aa), 4'(bb), qg);
                check("exh4_mul_back", 32'(ref_mul(int'(qg), bb, 4, 25)), 32'(aa));
            end
        end

        // Random requests, including illegal degrees, polynomials and operands.
        for (int n = 0; n < 60; n++) begin
            run_op(3'($urandom_range(1, 5)), 5'($urandom_range(0, 31)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), qg);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
